pipe_fetch_queue: RTL and testbench
===================================

// Module: pipe_fetch_queue
// PURPOSE
//   Parametrised IF->ID decoupling stage, replacing the single-entry IF/ID register.
//   - Holds up to DEPTH fetched {pc, raw_instr} packets in a circular buffer.
//   - valid/ready handshake on both sides; ID stall = deq_ready low.
//   - Flush on redirect; replays the last issued packet as a bubble when empty.
// PARAMETERS
//   DATA_W  96  packet width ({pc[63:0], raw_instr[31:0]} by default)
//   DEPTH   4   entries; power of two, >= 2
// PORTS
//   clk        in   1                  clock, all state on posedge
//   reset      in   1                  synchronous, active-high
//   flush      in   1                  branch/exception redirect: discard all entries
//   enq_valid  in   1                  IF presents a packet
//   enq_data   in   DATA_W             fetched packet
//   enq_ready  out  1                  queue can accept (count < DEPTH)
//   deq_ready  in   1                  ID accepts; low while Iwait/Dwait/exe waiting
//   deq_valid  out  1                  packet at head is real
//   deq_data   out  DATA_W             head packet, or last_data when !deq_valid
//   deq_bubble out  1                  = ~deq_valid
//   count      out  $clog2(DEPTH+1)    current occupancy
//   last_data  out  DATA_W             most recently dequeued packet
// BEHAVIOUR
//   - Reset: rd_ptr=wr_ptr=0, count=0, last_data=0.
//     Resulting outputs: deq_valid=0, deq_bubble=1, deq_data=0, enq_ready=1.
//   - enq fire = enq_valid & enq_ready & ~flush.
//     Writes mem[wr_ptr]; wr_ptr += 1, wrapping DEPTH-1 -> 0.
//   - deq fire = deq_valid & deq_ready & ~flush.
//     rd_ptr += 1 with wrap; last_data <= deq_data.
//   - count_next = count + enq_fire - deq_fire; enq_ready = (count != DEPTH), combinational.
//   - Full and deq fires: enq_ready is still 0 that cycle (no full pass-through); count -> DEPTH-1.
//   - Empty: deq_valid=0; deq_data=last_data, so ID sees the bubble carrying the previous pc/instr.
//   - Simultaneous enq and deq with 0 < count < DEPTH: count unchanged, both pointers advance.
//   - flush (no reset): next cycle count=0, pointers=0.
//     Same-cycle enq and deq are both discarded; last_data is NOT updated and keeps its value.
//   - reset dominates flush; reset mid-stream behaves identically to a flush and also clears last_data.
//   - Latency enq->deq_valid: 1 cycle (no bypass). Throughput: 1 packet/cycle.
//   - No overflow/underflow possible by construction; simulation asserts count <= DEPTH.
// CONFIGURATION
//   FETCHQ_BYPASS_EN defined:
//     - When count==0 & enq_valid & ~flush: deq_valid=1, deq_data=enq_data (0-cycle latency).
//     - If deq_ready is also high, the packet is consumed directly: no write, count stays 0,
//       last_data <= enq_data.
//     - If deq_ready is low, the packet is written normally.
//   FETCHQ_BYPASS_EN undefined:
//     - No combinational enq->deq path; deq outputs depend on registered state only.
// TESTING
//   1 reset=1 for 2 cycles -> count=0, deq_valid=0, deq_bubble=1, deq_data=0, enq_ready=1.
//   2 deq_ready=0; enqueue A,B,C,D on 4 cycles -> count=4, enq_ready=0.
//     A 5th enq E is ignored. Then deq_ready=1 -> A,B,C,D out in order, then deq_valid=0,
//     deq_data=D (last_data).
//   3 count=2; enq+deq together for 6 cycles -> count stays 2, order preserved,
//     pointers wrap past 3->0.
//   4 count=3; assert flush with enq_valid=1 -> next cycle count=0, deq_valid=0.
//     Flushed packet never appears; last_data unchanged.
//   5 count=0; enq X with deq_ready=1.
//     No bypass: X out 1 cycle later. FETCHQ_BYPASS_EN: X out same cycle, count stays 0.
//   6 count=4, deq_ready=1, enq_valid=1 same cycle -> head dequeues, enq not accepted, count=3.

Source files
------------

// File: rtl/pipe_fetch_queue.sv
// IF->ID decoupling queue: DEPTH-entry circular buffer of {pc, raw_instr} packets with flush and bubble replay.
// Optional same-cycle enq->deq bypass when empty is enabled by defining FETCHQ_BYPASS_EN.
module pipe_fetch_queue #(
   parameter int unsigned DATA_W = 96,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         enq_valid,
   input  logic [DATA_W-1:0]            enq_data,
   output logic                         enq_ready,
   input  logic                         deq_ready,
   output logic                         deq_valid,
   output logic [DATA_W-1:0]            deq_data,
   output logic                         deq_bubble,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [DATA_W-1:0]            last_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] last_data_q, last_data_d;

   logic empty_c, bypass_c, enq_fire_c, deq_fire_c, wr_en_c, rd_en_c;

   // Handshake, head selection and pointer/occupancy update.
   always_comb begin
      empty_c   = (count_q == '0);
      enq_ready = (count_q != CNT_W'(DEPTH));
      bypass_c  = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      bypass_c  = empty_c & enq_valid & ~flush;
`endif
      deq_valid  = ~empty_c | bypass_c;
      deq_bubble = ~deq_valid;
      if (bypass_c)
         deq_data = enq_data;
      else if (!empty_c)
         deq_data = mem_q[rd_ptr_q];
      else
         deq_data = last_data_q;

      enq_fire_c = enq_valid & enq_ready & ~flush;
      deq_fire_c = deq_valid & deq_ready & ~flush;
      // A bypassed packet consumed directly never touches the buffer.
      wr_en_c    = enq_fire_c & ~(bypass_c & deq_ready);
      rd_en_c    = deq_fire_c & ~bypass_c;

      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      last_data_d = last_data_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);
         if (deq_fire_c) last_data_d = deq_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         last_data_q <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         last_data_q <= last_data_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[wr_ptr_q] <= enq_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) assert (count_q <= CNT_W'(DEPTH));
   end

   assign count     = count_q;
   assign last_data = last_data_q;

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Scoreboard bench for pipe_fetch_queue: packets pushed at enqueue, popped and compared at dequeue.
module tb_pipe_fetch_queue;

   logic        clk = 1'b0;
   logic        reset, flush, enq_valid, deq_ready;
   logic [95:0] enq_data, deq_data, last_data;
   logic        enq_ready, deq_valid, deq_bubble;
   logic [2:0]  count;

   logic [95:0] exp_q[$];
   logic [95:0] m_last, exp;
   int          checks = 0;
   int          failures = 0;

   pipe_fetch_queue #(.DATA_W(96), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
      .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data),
      .deq_bubble(deq_bubble), .count(count), .last_data(last_data)
   );

   always #5 clk = ~clk;

   function automatic logic [95:0] pkt(int i);
      return {64'(64'h1000 + 4 * i), 32'(32'h0000_0013 + i)};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_in(logic ev, logic [95:0] ed, logic dr, logic fl);
      enq_valid = ev; enq_data = ed; deq_ready = dr; flush = fl;
   endtask

   task automatic pop_exp();
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else exp = 96'hdead;
   endtask

   task automatic test_reset();
      reset = 1'b1; set_in(1'b0, '0, 1'b0, 1'b0);
      tick(); tick();
      reset = 1'b0; #2;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
      checks++; if (deq_bubble !== 1'b1) begin failures++; $display("FAIL reset_bubble got=%b exp=1", deq_bubble); end
      checks++; if (deq_data !== 96'd0) begin failures++; $display("FAIL reset_deq_data got=%h exp=0", deq_data); end
      checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
      checks++; if (last_data !== 96'd0) begin failures++; $display("FAIL reset_last_data got=%h exp=0", last_data); end
      m_last = '0; exp_q.delete();
      tick();
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, pkt(i), 1'b0, 1'b0); #2;
         checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL fill_enq_ready[%0d] got=%b exp=1", i, enq_ready); end
         exp_q.push_back(pkt(i));
         tick();
      end
      set_in(1'b1, pkt(4), 1'b0, 1'b0); #2;
      checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL full_enq_ready got=%b exp=0", enq_ready); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, '0, 1'b1, 1'b0); #2;
         pop_exp();
         checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, deq_valid); end
         checks++; if (deq_data !== exp) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, deq_data, exp); end
         m_last = exp;
         tick();
      end
      #2;
      checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%b exp=0", deq_valid); end
      checks++; if (deq_bubble !== 1'b1) begin failures++; $display("FAIL empty_bubble got=%b exp=1", deq_bubble); end
      checks++; if (deq_data !== m_last) begin failures++; $display("FAIL empty_replay got=%h exp=%h", deq_data, m_last); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", count); end
      tick();
   endtask

   task automatic test_concurrent();
      for (int i = 10; i < 12; i++) begin
         set_in(1'b1, pkt(i), 1'b0, 1'b0); exp_q.push_back(pkt(i)); tick();
      end
      for (int i = 12; i < 18; i++) begin
         set_in(1'b1, pkt(i), 1'b1, 1'b0); #2;
         pop_exp();
         checks++; if (count !== 3'd2) begin failures++; $display("FAIL conc_count[%0d] got=%0d exp=2", i, count); end
         checks++; if (deq_data !== exp || deq_valid !== 1'b1) begin failures++; $display("FAIL conc_data[%0d] got=%h/%b exp=%h/1", i, deq_data, deq_valid, exp); end
         exp_q.push_back(pkt(i)); m_last = exp;
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         set_in(1'b0, '0, 1'b1, 1'b0); #2;
         pop_exp();
         checks++; if (deq_data !== exp || deq_valid !== 1'b1) begin failures++; $display("FAIL conc_tail[%0d] got=%h/%b exp=%h/1", i, deq_data, deq_valid, exp); end
         m_last = exp;
         tick();
      end
   endtask

   task automatic test_flush();
      for (int i = 20; i < 23; i++) begin
         set_in(1'b1, pkt(i), 1'b0, 1'b0); tick();
      end
      set_in(1'b1, pkt(23), 1'b1, 1'b1);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0); #2;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
      checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", deq_valid); end
      checks++; if (last_data !== m_last) begin failures++; $display("FAIL flush_last got=%h exp=%h", last_data, m_last); end
      checks++; if (deq_data !== m_last) begin failures++; $display("FAIL flush_replay got=%h exp=%h", deq_data, m_last); end
      exp_q.delete();
      tick();
   endtask

   task automatic test_empty_enq();
      set_in(1'b1, pkt(30), 1'b1, 1'b0); exp_q.push_back(pkt(30)); #2;
`ifdef FETCHQ_BYPASS_EN
      pop_exp();
      checks++; if (deq_valid !== 1'b1 || deq_data !== exp) begin failures++; $display("FAIL bypass_out got=%h/%b exp=%h/1", deq_data, deq_valid, exp); end
      m_last = exp;
      tick();
      set_in(1'b0, '0, 1'b1, 1'b0); #2;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
      checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL nobypass_early got=%b exp=0", deq_valid); end
      tick();
      set_in(1'b0, '0, 1'b1, 1'b0); #2;
      pop_exp();
      checks++; if (deq_valid !== 1'b1 || deq_data !== exp) begin failures++; $display("FAIL nobypass_out got=%h/%b exp=%h/1", deq_data, deq_valid, exp); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL nobypass_count got=%0d exp=1", count); end
      m_last = exp;
      tick(); #2;
`endif
      checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL empty_enq_after got=%b exp=0", deq_valid); end
      checks++; if (last_data !== m_last) begin failures++; $display("FAIL empty_enq_last got=%h exp=%h", last_data, m_last); end
      tick();
   endtask

   task automatic test_full_deq_enq();
      for (int i = 40; i < 44; i++) begin
         set_in(1'b1, pkt(i), 1'b0, 1'b0); exp_q.push_back(pkt(i)); tick();
      end
      set_in(1'b1, pkt(44), 1'b1, 1'b0); #2;
      pop_exp();
      checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL fulldeq_enq_ready got=%b exp=0", enq_ready); end
      checks++; if (deq_valid !== 1'b1 || deq_data !== exp) begin failures++; $display("FAIL fulldeq_head got=%h/%b exp=%h/1", deq_data, deq_valid, exp); end
      m_last = exp;
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0); #2;
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL fulldeq_count got=%0d exp=3", count); end
      checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL fulldeq_ready_after got=%b exp=1", enq_ready); end
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, '0, 1'b1, 1'b0); #2;
         pop_exp();
         checks++; if (deq_valid !== 1'b1 || deq_data !== exp) begin failures++; $display("FAIL fulldeq_drain[%0d] got=%h/%b exp=%h/1", i, deq_data, deq_valid, exp); end
         m_last = exp;
         tick();
      end
      #2;
      checks++; if (deq_valid !== 1'b0 || deq_data !== m_last) begin failures++; $display("FAIL fulldeq_empty got=%h/%b exp=%h/0", deq_data, deq_valid, m_last); end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 50; i < 52; i++) begin
         set_in(1'b1, pkt(i), 1'b0, 1'b0); tick();
      end
      set_in(1'b0, '0, 1'b1, 1'b0); tick();
      reset = 1'b1; set_in(1'b1, pkt(52), 1'b1, 1'b0);
      tick();
      reset = 1'b0; set_in(1'b0, '0, 1'b0, 1'b0); #2;
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", count); end
      checks++; if (last_data !== 96'd0) begin failures++; $display("FAIL midreset_last got=%h exp=0", last_data); end
      checks++; if (deq_valid !== 1'b0 || deq_data !== 96'd0) begin failures++; $display("FAIL midreset_out got=%h/%b exp=0/0", deq_data, deq_valid); end
      exp_q.delete(); m_last = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_concurrent();
      test_flush();
      test_empty_enq();
      test_full_deq_enq();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
